// File: rtl/eth_frame_pkg.sv
// Shared definitions for the Ethernet frame wrapper: magic tags, header/trailer
// field positions, FSM encoding and small field-building helpers.
package eth_frame_pkg;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;
  localparam logic [15:0] TRL_MAGIC_DEF = 16'h5AA5;

  localparam int MAGIC_LSB     = 48;
  localparam int HDR_NODE_LSB  = 40;
  localparam int HDR_TYPE_LSB  = 32;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int TRL_BYTES_LSB = 16;
  localparam int TRL_TRUNC_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2,
    ST_TRL     = 2'd3
  } frm_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, keep[i]};
    end
    return cnt;
  endfunction

  function automatic logic [63:0] make_header(input logic [15:0] magic, input logic [3:0] node,
                                              input logic [3:0] etype, input logic [15:0] seq);
    logic [63:0] w;
    w = 64'd0;
    w[MAGIC_LSB +: 16]    = magic;
    w[HDR_NODE_LSB +: 4]  = node;
    w[HDR_TYPE_LSB +: 4]  = etype;
    w[HDR_SEQ_LSB +: 16]  = seq;
    return w;
  endfunction

  function automatic logic [63:0] make_trailer(input logic [15:0] magic, input logic [15:0] bytes,
                                               input logic trunc);
    logic [63:0] w;
    w = 64'd0;
    w[MAGIC_LSB +: 16]     = magic;
    w[TRL_BYTES_LSB +: 16] = bytes;
    w[TRL_TRUNC_BIT]       = trunc;
    return w;
  endfunction

endpackage

// File: rtl/eth_axis_framer.sv
// Wraps each received AXIS Ethernet frame in a header and trailer beat, cut-through,
// with one registered output stage and truncation of over-long frames.
module eth_axis_framer
  import eth_frame_pkg::*;
#(
  parameter int          MAX_BEATS = 190,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter logic [15:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
  input  logic        tx_clk_out,
  input  logic        sys_rst_n,
  input  logic [3:0]  node_id,
  input  logic [3:0]  eth_type,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        trunc_pulse
);

  localparam logic [12:0] LAST_BEAT = 13'(MAX_BEATS - 1);

  frm_state_e  state_r;
  frm_state_e  state_s;
  logic [15:0] seq_r;
  logic [12:0] beat_cnt_r;
  logic [15:0] byte_cnt_r;
  logic        trunc_r;

  logic out_free_s;
  logic s_ready_s;
  logic load_hdr_s;
  logic fwd_s;
  logic load_trl_s;
  logic trunc_hit_s;

  assign out_free_s    = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = s_ready_s;

  // Next-state decode and per-cycle load strobes for the output register.
  always_comb begin
    state_s     = state_r;
    s_ready_s   = 1'b0;
    load_hdr_s  = 1'b0;
    fwd_s       = 1'b0;
    load_trl_s  = 1'b0;
    trunc_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_axis_tvalid && out_free_s) begin
          load_hdr_s = 1'b1;
          state_s    = ST_PAYLOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        s_ready_s = out_free_s;
        if (s_axis_tvalid && out_free_s) begin
          fwd_s = 1'b1;
          if (s_axis_tlast) begin
            state_s = ST_TRL;
          end else if (beat_cnt_r == LAST_BEAT) begin
            trunc_hit_s = 1'b1;
            state_s     = ST_DROP;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        s_ready_s = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_s = ST_TRL;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_TRL: begin
        if (out_free_s) begin
          load_trl_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_TRL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, sequence number and per-frame beat/byte/truncation counters.
  always_ff @(posedge tx_clk_out) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      seq_r       <= 16'd0;
      beat_cnt_r  <= 13'd0;
      byte_cnt_r  <= 16'd0;
      trunc_r     <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      state_r     <= state_s;
      trunc_pulse <= trunc_hit_s;
      if (load_hdr_s) begin
        beat_cnt_r <= 13'd0;
        byte_cnt_r <= 16'd0;
        trunc_r    <= 1'b0;
      end else if (fwd_s) begin
        beat_cnt_r <= beat_cnt_r + 13'd1;
        byte_cnt_r <= byte_cnt_r + {12'd0, popcount8(s_axis_tkeep)};
        if (trunc_hit_s) begin
          trunc_r <= 1'b1;
        end
      end
      if (load_trl_s) begin
        seq_r <= seq_r + 16'd1;
      end
    end
  end

  // Output stage: loads header, payload or trailer whenever the slot is free.
  always_ff @(posedge tx_clk_out) begin
    if (!sys_rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 64'd0;
      m_axis_tkeep  <= 8'd0;
      m_axis_tlast  <= 1'b0;
    end else if (out_free_s) begin
      if (load_hdr_s) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= make_header(HDR_MAGIC, node_id, eth_type, seq_r);
        m_axis_tkeep  <= 8'hFF;
        m_axis_tlast  <= 1'b0;
      end else if (fwd_s) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= s_axis_tkeep;
        m_axis_tlast  <= 1'b0;
      end else if (load_trl_s) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= make_trailer(TRL_MAGIC, byte_cnt_r, trunc_r);
        m_axis_tkeep  <= 8'hFF;
        m_axis_tlast  <= 1'b1;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_axis_framer.sv
// Scoreboard bench for eth_axis_framer: a driver pushes expected output beats,
// a monitor pops and compares every accepted output beat.
module tb_eth_axis_framer;

  localparam int MAXB = 8;

  logic        clk;
  logic        sys_rst_n;
  logic [3:0]  node_id;
  logic [3:0]  eth_type;
  logic        s_valid;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_ready;
  logic        trunc_pulse;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          xfer_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          trunc_seen = 0;
  int          trunc_exp = 0;
  int          rand_ready = 0;
  logic [15:0] seq_m = 16'd0;

  eth_axis_framer #(.MAX_BEATS(MAXB)) dut (
    .tx_clk_out    (clk),
    .sys_rst_n     (sys_rst_n),
    .node_id       (node_id),
    .eth_type      (eth_type),
    .s_axis_tvalid (s_valid),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tvalid (m_valid),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .trunc_pulse   (trunc_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready != 0) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compare accepted beats against the scoreboard and check stall stability.
  initial begin : monitor
    beat_t e;
    beat_t held;
    logic  stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        checks++;
        if (!m_valid || {m_data, m_keep, m_last} != held) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h/%h/%0b required v=1 %h/%h/%0b",
                   m_valid, m_data, m_keep, m_last, held.d, held.k, held.l);
        end
      end
      if (trunc_pulse) trunc_seen++;
      if (m_valid && m_ready) begin
        xfer_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h/%h/%0b with nothing expected", m_data, m_keep, m_last);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_keep !== e.k || m_last !== e.l) begin
            errors++;
            $display("FAIL out_beat: got %h/%h/%0b required %h/%h/%0b",
                     m_data, m_keep, m_last, e.d, e.k, e.l);
          end
        end
      end
      stall_prev = m_valid && !m_ready && sys_rst_n;
      held = '{d: m_data, k: m_keep, l: m_last};
    end
  end

  function automatic beat_t hdr_beat(input logic [3:0] nid, input logic [3:0] typ, input logic [15:0] sq);
    return '{d: {16'hA55A, 4'h0, nid, 4'h0, typ, sq, 16'h0000}, k: 8'hFF, l: 1'b0};
  endfunction

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, got, req);
    end
  endtask

  task automatic mid_reset();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    sys_rst_n = 1'b0;
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge clk);
    check_bit("midreset_tvalid", m_valid, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending: got %0d beats outstanding required 0", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame and record its expected header, kept payload and trailer.
  task automatic send_frame(input int nb, input logic [7:0] lkeep, input int zidx,
                            input int rst_at, input int chg_at, input logic [7:0] tag);
    int          kept;
    int          t;
    logic [15:0] bytes;
    logic        tr;
    logic [7:0]  kp;
    exp_q.push_back(hdr_beat(node_id, eth_type, seq_m));
    kept  = 0;
    bytes = 16'd0;
    tr    = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        mid_reset();
        seq_m = 16'd0;
        exp_q.push_back(hdr_beat(node_id, eth_type, seq_m));
        kept  = 0;
        bytes = 16'd0;
        tr    = 1'b0;
      end
      kp = (i == nb - 1) ? lkeep : ((i == zidx) ? 8'h00 : 8'hFF);
      s_valid = 1'b1;
      s_data  = {tag, 8'(i), 48'h0000_BEEF_0000 + 48'(i)};
      s_keep  = kp;
      s_last  = (i == nb - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (tr && t == 0) check_bit("drop_tready", s_ready, 1'b1);
        if (s_ready) begin
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
        #1;
        t++;
        if (t > 1000) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: beat %0d of tag %h never accepted", i, tag);
          break;
        end
      end
      if (!tr) begin
        exp_q.push_back('{d: s_data, k: kp, l: 1'b0});
        bytes = bytes + 16'($countones(kp));
        kept++;
        if (kept == MAXB && i != nb - 1) begin
          tr = 1'b1;
          trunc_exp++;
        end
      end
      if (i == chg_at) node_id = ~node_id;
    end
    exp_q.push_back('{d: {16'h5AA5, 16'h0000, bytes, 15'h0000, tr}, k: 8'hFF, l: 1'b1});
    seq_m = seq_m + 16'd1;
  endtask

  task automatic go_idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d beats missing required 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    sys_rst_n = 1'b0;
    node_id   = 4'h3;
    eth_type  = 4'h1;
    s_valid   = 1'b0;
    s_data    = 64'd0;
    s_keep    = 8'h00;
    s_last    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_m_tvalid", m_valid, 1'b0);
    check_bit("rst_m_tlast", m_last, 1'b0);
    check_bit("rst_s_tready", s_ready, 1'b0);
    check_bit("rst_trunc_pulse", trunc_pulse, 1'b0);
    checks++;
    if (m_data !== 64'd0 || m_keep !== 8'h00) begin
      errors++;
      $display("FAIL rst_m_data: got %h/%h required 0/00", m_data, m_keep);
    end
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 8-beat frame ending exactly at MAX_BEATS; node_id changes mid-frame.
    send_frame(8, 8'h0F, -1, -1, 3, 8'h01);
    go_idle();
    drain("t1");

    // Back-to-back single-beat frames, no output gaps.
    node_id = 4'h3;
    xfer_cyc.delete();
    send_frame(1, 8'hFF, -1, -1, -1, 8'h21);
    send_frame(1, 8'hFF, -1, -1, -1, 8'h22);
    send_frame(1, 8'hFF, -1, -1, -1, 8'h23);
    go_idle();
    drain("t2");
    checks++;
    if (xfer_cyc.size() != 9 || xfer_cyc[8] - xfer_cyc[0] != 8) begin
      errors++;
      $display("FAIL b2b_gap: got %0d beats over span %0d required 9 over 8", xfer_cyc.size(),
               (xfer_cyc.size() > 0) ? xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[0] : -1);
    end

    // Truncated frame and a frame with an empty-keep beat.
    send_frame(10, 8'hFF, -1, -1, -1, 8'h31);
    go_idle();
    drain("t3");
    checks++;
    if (trunc_seen != trunc_exp) begin
      errors++;
      $display("FAIL trunc_pulse_count: got %0d required %0d", trunc_seen, trunc_exp);
    end
    send_frame(5, 8'h03, 2, -1, -1, 8'h32);
    go_idle();
    drain("t3b");

    // Random downstream backpressure.
    rand_ready = 1;
    send_frame(20, 8'h3F, -1, -1, -1, 8'h41);
    send_frame(6, 8'h01, 1, -1, -1, 8'h42);
    go_idle();
    drain("t4");
    rand_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset pulse mid-frame; the remainder becomes a fresh frame with seq 0.
    send_frame(12, 8'hFF, -1, 5, -1, 8'h51);
    go_idle();
    drain("t5");

    // Sequence wrap from FFFF to 0000.
    force dut.seq_r = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.seq_r;
    seq_m = 16'hFFFF;
    send_frame(1, 8'hFF, -1, -1, -1, 8'h61);
    send_frame(1, 8'hFF, -1, -1, -1, 8'h62);
    go_idle();
    drain("t6");

    checks++;
    if (trunc_seen != trunc_exp) begin
      errors++;
      $display("FAIL trunc_pulse_total: got %0d required %0d", trunc_seen, trunc_exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
